// File: rtl/sub_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sub_pipe_unit
//  Purpose  : Two-stage pipelined subtractor, diff = a - b = a + ~b + 1.
//             Stage 1 forms the low half and its carry; stage 2 forms the
//             high half and the flags. Valid/ready handshakes on both sides
//             allow one operation per cycle with stall on backpressure.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             in_valid/in_ready, a, b            - operand handshake
//             out_valid/out_ready, diff, borrow, overflow, zero - result
//  Params   : WIDTH - operand width (even; split at WIDTH/2)
//  Revision : 1.0 - initial release
// ============================================================================
module sub_pipe_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int c_HALF = WIDTH / 2;

    // Stage 1 state
    logic              r_s1_valid;
    logic [c_HALF-1:0] r_s1_lo;
    logic              r_s1_c_lo;
    logic [c_HALF-1:0] r_s1_a_hi;
    logic [c_HALF-1:0] r_s1_nb_hi;   // already inverted subtrahend high half
    logic              r_s1_a_msb;
    logic              r_s1_b_msb;

    // Stage 2 state (drives the outputs directly)
    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow;
    logic              r_overflow;
    logic              r_zero;

    // Handshake / advance
    logic              w_s2_adv;
    logic              w_s1_adv;

    // Datapath
    logic [c_HALF:0]   w_lo_sum;
    logic [c_HALF:0]   w_hi_sum;
    logic [WIDTH-1:0]  w_diff;

    // A stage may advance when it is empty or its successor can take it.
    // in_ready depends only on state and out_ready, never on in_valid.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // Low half: the "+1" of the two's-complement negation enters as carry-in.
    assign w_lo_sum = {1'b0, a[c_HALF-1:0]} + {1'b0, ~b[c_HALF-1:0]}
                    + {{c_HALF{1'b0}}, 1'b1};

    // High half: carry from the low half is the carry-in.
    assign w_hi_sum = {1'b0, r_s1_a_hi} + {1'b0, r_s1_nb_hi}
                    + {{c_HALF{1'b0}}, r_s1_c_lo};

    assign w_diff = {w_hi_sum[c_HALF-1:0], r_s1_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_c_lo  <= 1'b0;
            r_s1_a_hi  <= '0;
            r_s1_nb_hi <= '0;
            r_s1_a_msb <= 1'b0;
            r_s1_b_msb <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            // Data only loads with a real operand; bubbles leave it stale.
            if (in_valid) begin
                r_s1_lo    <= w_lo_sum[c_HALF-1:0];
                r_s1_c_lo  <= w_lo_sum[c_HALF];
                r_s1_a_hi  <= a[WIDTH-1:c_HALF];
                r_s1_nb_hi <= ~b[WIDTH-1:c_HALF];
                r_s1_a_msb <= a[WIDTH-1];
                r_s1_b_msb <= b[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            // Result fields change only when a valid op arrives, so a held
            // result stays stable and an invalid slot never disturbs them.
            if (r_s1_valid) begin
                r_diff     <= w_diff;
                r_borrow   <= ~w_hi_sum[c_HALF];
                // Operands of differing sign overflow when the result sign
                // disagrees with the minuend sign.
                r_overflow <= (r_s1_a_msb != r_s1_b_msb) &&
                              (w_diff[WIDTH-1] != r_s1_a_msb);
                r_zero     <= (w_diff == '0);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire
